// File: rtl/m_scan_timing_pkg.sv
// Shared timing defaults, frame-total derivation and sync polarity for the scan timing generator.
package m_scan_timing_pkg;

    localparam int unsigned H_VISIBLE_DEF = 800;
    localparam int unsigned H_FRONT_DEF   = 56;
    localparam int unsigned H_SYNC_DEF    = 120;
    localparam int unsigned H_BACK_DEF    = 64;

    localparam int unsigned V_VISIBLE_DEF = 600;
    localparam int unsigned V_FRONT_DEF   = 37;
    localparam int unsigned V_SYNC_DEF    = 6;
    localparam int unsigned V_BACK_DEF    = 23;

    localparam int unsigned BUS_DEF  = 11;
    localparam int unsigned PIPE_DEF = 2;

    localparam logic SYNC_ACTIVE = 1'b1;

    function automatic int unsigned scan_total(
        input int unsigned visible,
        input int unsigned front,
        input int unsigned sync,
        input int unsigned back
    );
        return visible + front + sync + back;
    endfunction

endpackage

// File: rtl/m_scan_delay.sv
// CE-qualified, reset-clearable shift register; DEPTH=0 is a pass-through forced low in reset.
module m_scan_delay #(
    parameter int unsigned W     = 3,
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ce,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_ctl;
            assign unused_ctl = clk ^ ce;
            assign dout       = rst_n ? din : '0;
        end else begin : g_shift
            logic [DEPTH-1:0][W-1:0] stage_q;
            logic [DEPTH-1:0][W-1:0] stage_d;

            always_comb begin
                stage_d = stage_q;
                if (ce) begin
                    stage_d[0] = din;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        stage_d[i] = stage_q[i-1];
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stage_q <= '0;
                end else begin
                    stage_q <= stage_d;
                end
            end

            assign dout = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/m_scan_timing.sv
// Raster scan timing generator: pixel/line counters, delayed syncs/DE and frame-boundary flag.
// Optional feature macro SCAN_HOLD_EN: HOLD sampled at frame wrap keeps NEXT_FRAME high for one more frame.
module m_scan_timing
    import m_scan_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
    parameter int unsigned H_FRONT   = H_FRONT_DEF,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BACK    = H_BACK_DEF,
    parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
    parameter int unsigned V_FRONT   = V_FRONT_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_BACK    = V_BACK_DEF,
    parameter int unsigned BUS       = BUS_DEF,
    parameter int unsigned PIPE      = PIPE_DEF
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           CE,
    input  logic           HOLD,
    output logic [BUS-1:0] HDATA,
    output logic [BUS-1:0] VDATA,
    output logic           NEXT_FRAME,
    output logic           HSYNC,
    output logic           VSYNC,
    output logic           DE
);

    localparam int unsigned H_TOTAL = scan_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL = scan_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    localparam logic [BUS-1:0] H_LAST   = BUS'(H_TOTAL - 1);
    localparam logic [BUS-1:0] V_LAST   = BUS'(V_TOTAL - 1);
    localparam logic [BUS-1:0] H_VIS    = BUS'(H_VISIBLE);
    localparam logic [BUS-1:0] V_VIS    = BUS'(V_VISIBLE);
    localparam logic [BUS-1:0] HS_START = BUS'(H_VISIBLE + H_FRONT);
    localparam logic [BUS-1:0] HS_END   = BUS'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [BUS-1:0] VS_START = BUS'(V_VISIBLE + V_FRONT);
    localparam logic [BUS-1:0] VS_END   = BUS'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [BUS-1:0] hdata_q, hdata_d;
    logic [BUS-1:0] vdata_q, vdata_d;
    logic           next_frame_q, next_frame_d;
    logic           h_wrap_c, v_wrap_c, frame_wrap_c;
    logic           hold_c;
    logic           hsync_c, vsync_c, de_c;
    logic [2:0]     timing_dly;

    assign h_wrap_c     = (hdata_q == H_LAST);
    assign v_wrap_c     = (vdata_q == V_LAST);
    assign frame_wrap_c = CE && h_wrap_c && v_wrap_c;

    // Counters: the line counter steps in the same cycle the pixel counter wraps.
    always_comb begin
        hdata_d = hdata_q;
        vdata_d = vdata_q;
        if (CE) begin
            hdata_d = h_wrap_c ? '0 : hdata_q + BUS'(1);
            if (h_wrap_c) begin
                vdata_d = v_wrap_c ? '0 : vdata_q + BUS'(1);
            end
        end
    end

`ifdef SCAN_HOLD_EN
    logic hold_q, hold_d;

    always_comb begin
        hold_d = hold_q;
        if (frame_wrap_c) begin
            hold_d = HOLD;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hold_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign hold_c = hold_d;
`else
    logic unused_hold;
    assign unused_hold = HOLD ^ frame_wrap_c;
    assign hold_c      = 1'b0;
`endif

    // Flag tracks the next counter values so it changes together with VDATA.
    always_comb begin
        next_frame_d = (vdata_d >= V_VIS) || hold_c;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hdata_q      <= '0;
            vdata_q      <= '0;
            next_frame_q <= 1'b0;
        end else begin
            hdata_q      <= hdata_d;
            vdata_q      <= vdata_d;
            next_frame_q <= next_frame_d;
        end
    end

    always_comb begin
        hsync_c = ((hdata_q >= HS_START) && (hdata_q < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_c = ((vdata_q >= VS_START) && (vdata_q < VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        de_c    = (hdata_q < H_VIS) && (vdata_q < V_VIS);
    end

    m_scan_delay #(
        .W     (3),
        .DEPTH (PIPE)
    ) u_delay (
        .clk   (CLK),
        .rst_n (RST_N),
        .ce    (CE),
        .din   ({hsync_c, vsync_c, de_c}),
        .dout  (timing_dly)
    );

    assign HDATA      = hdata_q;
    assign VDATA      = vdata_q;
    assign NEXT_FRAME = next_frame_q;
    assign {HSYNC, VSYNC, DE} = timing_dly;

endmodule

// File: tb/tb_m_scan_timing.sv
// Directed bench: default-timing instance plus two small-raster instances (PIPE=2 and PIPE=0).
module tb_m_scan_timing;

`ifdef SCAN_HOLD_EN
    localparam logic HOLD_EXP = 1'b1;
`else
    localparam logic HOLD_EXP = 1'b0;
`endif

    logic CLK, RST_N, CE, HOLD;

    logic [10:0] d_hdata, d_vdata;
    logic        d_nf, d_hs, d_vs, d_de;
    logic [4:0]  s_hdata, s_vdata;
    logic        s_nf, s_hs, s_vs, s_de;
    logic [4:0]  p_hdata, p_vdata;
    logic        p_nf, p_hs, p_vs, p_de;

    int n_cmp = 0;
    int n_err = 0;

    // Defaults: 1040 x 666, PIPE=2.
    m_scan_timing u_dflt (
        .CLK(CLK), .RST_N(RST_N), .CE(CE), .HOLD(HOLD),
        .HDATA(d_hdata), .VDATA(d_vdata), .NEXT_FRAME(d_nf),
        .HSYNC(d_hs), .VSYNC(d_vs), .DE(d_de)
    );

    // Small raster: H 8/2/3/3 (16), V 4/1/2/1 (8), 128 cycles per frame.
    m_scan_timing #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .BUS(5), .PIPE(2)
    ) u_small (
        .CLK(CLK), .RST_N(RST_N), .CE(CE), .HOLD(HOLD),
        .HDATA(s_hdata), .VDATA(s_vdata), .NEXT_FRAME(s_nf),
        .HSYNC(s_hs), .VSYNC(s_vs), .DE(s_de)
    );

    m_scan_timing #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .BUS(5), .PIPE(0)
    ) u_pass (
        .CLK(CLK), .RST_N(RST_N), .CE(CE), .HOLD(HOLD),
        .HDATA(p_hdata), .VDATA(p_vdata), .NEXT_FRAME(p_nf),
        .HSYNC(p_hs), .VSYNC(p_vs), .DE(p_de)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int waited;
        int j;
        int n;

        RST_N = 1'b0;
        CE    = 1'b0;
        HOLD  = 1'b0;
        step(3);

        chk("rst_d_hdata", 32'(d_hdata), 0);
        chk("rst_d_vdata", 32'(d_vdata), 0);
        chk("rst_d_nf",    32'(d_nf),    0);
        chk("rst_d_hs",    32'(d_hs),    0);
        chk("rst_d_vs",    32'(d_vs),    0);
        chk("rst_d_de",    32'(d_de),    0);
        chk("rst_s_hdata", 32'(s_hdata), 0);
        chk("rst_s_nf",    32'(s_nf),    0);
        chk("rst_p_de",    32'(p_de),    0);
        chk("rst_p_hs",    32'(p_hs),    0);

        // Release: (0,0) is visible, so the pass-through DE goes high at once; delayed DE does not.
        RST_N = 1'b1;
        CE    = 1'b1;
        #1;
        chk("rel_p_de", 32'(p_de), 1);
        chk("rel_d_de", 32'(d_de), 0);
        #1;

        // One full default line: HSYNC window 856..975, DE window 0..799, both seen 2 cycles late.
        for (int i = 0; i <= 1040; i++) begin
            j = i - 2;
            chk("line_h",  32'(d_hdata), (i == 1040) ? 0 : i);
            chk("line_v",  32'(d_vdata), (i == 1040) ? 1 : 0);
            chk("line_hs", 32'(d_hs), 32'((i >= 2) && (j >= 856) && (j < 976)));
            chk("line_de", 32'(d_de), 32'((i >= 2) && (j < 800)));
            if (i < 1040) step(1);
        end
        chk("line_nf", 32'(d_nf), 0);

        // t=1078: default (38,1); small (6,3) with DE from (4,3).
        step(38);
        chk("mid_d_h",  32'(d_hdata), 38);
        chk("mid_d_v",  32'(d_vdata), 1);
        chk("mid_d_de", 32'(d_de),    1);
        chk("mid_d_vs", 32'(d_vs),    0);
        chk("mid_s_h",  32'(s_hdata), 6);
        chk("mid_s_v",  32'(s_vdata), 3);
        chk("mid_s_de", 32'(s_de),    1);
        chk("mid_s_hs", 32'(s_hs),    0);
        chk("mid_s_nf", 32'(s_nf),    0);
        chk("mid_p_de", 32'(p_de),    1);

        // Mid-frame asynchronous reset: everything reads 0 before the next edge.
        RST_N = 1'b0;
        #1;
        chk("arst_d_h",  32'(d_hdata), 0);
        chk("arst_d_v",  32'(d_vdata), 0);
        chk("arst_d_de", 32'(d_de),    0);
        chk("arst_s_h",  32'(s_hdata), 0);
        chk("arst_s_v",  32'(s_vdata), 0);
        chk("arst_s_de", 32'(s_de),    0);
        chk("arst_p_de", 32'(p_de),    0);

        step(1);
        RST_N = 1'b1;
        CE    = 1'b0;
        step(1);
        chk("ce0_hold_h", 32'(s_hdata), 0);

        // CE every other cycle: one advance per two clocks, frozen in between.
        for (int c = 0; c < 20; c++) begin
            CE = (c % 2 == 0);
            step(1);
            n = c / 2 + 1;
            chk("ce_s_h",  32'(s_hdata), n);
            chk("ce_s_v",  32'(s_vdata), 0);
            chk("ce_s_de", 32'(s_de),    32'((n >= 2) && (n <= 9)));
            chk("ce_p_de", 32'(p_de),    32'(n < 8));
        end
        CE = 1'b1;

        // Small raster now at (10,0); NEXT_FRAME must rise 54 cycles later at (0,4).
        waited = 0;
        while (s_nf !== 1'b1 && waited < 300) begin
            step(1);
            waited++;
        end
        chk("nf_rise_wait", waited, 54);
        chk("nf_rise_h",    32'(s_hdata), 0);
        chk("nf_rise_v",    32'(s_vdata), 4);

        step(17);
        chk("vs_before", 32'(s_vs), 0);
        step(1);
        chk("vs_after",  32'(s_vs), 1);
        step(46);
        chk("wrap_h",  32'(s_hdata), 0);
        chk("wrap_v",  32'(s_vdata), 0);
        chk("wrap_nf", 32'(s_nf),    0);
        chk("wrap_vs", 32'(s_vs),    0);

        step(64);
        chk("nf_rise2", 32'(s_nf), 1);
        HOLD = 1'b1;
        step(64);
        chk("hold_wrap_v",  32'(s_vdata), 0);
        chk("hold_wrap_nf", 32'(s_nf),    HOLD_EXP);
        HOLD = 1'b0;
        step(10);
        chk("hold_mid_nf", 32'(s_nf),    HOLD_EXP);
        chk("hold_mid_h",  32'(s_hdata), 10);
        step(54);
        chk("hold_blank_nf", 32'(s_nf),    1);
        chk("hold_blank_v",  32'(s_vdata), 4);
        step(64);
        chk("release_nf", 32'(s_nf),    0);
        chk("release_v",  32'(s_vdata), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
